// File: rtl/axi_lite_read_arbiter_pkg.sv
// rtl/axi_lite_read_arbiter_pkg.sv - state encoding and response codes for the read arbiter
package axi_lite_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of a master index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_read_arbiter_if.sv
// rtl/axi_lite_read_arbiter_if.sv - master-side and slave-side read channel bundle
interface axi_lite_read_arbiter_if #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_M-1:0]        m_arvalid;
  logic [NUM_M-1:0]        m_arready;
  logic [NUM_M*ADDR_W-1:0] m_araddr;
  logic [NUM_M*3-1:0]      m_arprot;
  logic [NUM_M-1:0]        m_rvalid;
  logic [NUM_M-1:0]        m_rready;
  logic [DATA_W-1:0]       m_rdata;
  logic [1:0]              m_rresp;
  logic                    s_arvalid;
  logic                    s_arready;
  logic [ADDR_W-1:0]       s_araddr;
  logic [2:0]              s_arprot;
  logic                    s_rvalid;
  logic                    s_rready;
  logic [DATA_W-1:0]       s_rdata;
  logic [1:0]              s_rresp;
  logic [NUM_M-1:0]        grant;

  // Arbiter view: receives the masters' requests, drives the shared slave port.
  modport slave (
    input  m_arvalid, m_araddr, m_arprot, m_rready,
    input  s_arready, s_rvalid, s_rdata, s_rresp,
    output m_arready, m_rvalid, m_rdata, m_rresp,
    output s_arvalid, s_araddr, s_arprot, s_rready, grant
  );

  // Environment view: the requesting masters plus the downstream slave.
  modport master (
    output m_arvalid, m_araddr, m_arprot, m_rready,
    output s_arready, s_rvalid, s_rdata, s_rresp,
    input  m_arready, m_rvalid, m_rdata, m_rresp,
    input  s_arvalid, s_araddr, s_arprot, s_rready, grant
  );
endinterface

// File: rtl/axi_lite_read_arbiter_rr_arbiter.sv
// rtl/axi_lite_read_arbiter_rr_arbiter.sv - combinational round-robin winner select
module rr_arbiter
  import axi_lite_read_arbiter_pkg::*;
#(
  parameter  int NUM_M = 2,
  localparam int IDX_W = idx_w(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [NUM_M-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             winner_valid
);

  logic [IDX_W-1:0] cand;

  // Scan from last+1 with wrap so the previous owner is considered last.
  always_comb begin
    winner_idx   = '0;
    winner_valid = 1'b0;
    cand         = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_M);
      if (!winner_valid && req[cand]) begin
        winner_valid = 1'b1;
        winner_idx   = cand;
      end
    end
    winner = winner_valid ? (NUM_M'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// rtl/axi_lite_read_arbiter.sv - round-robin sharing of one AXI4-Lite read port
module axi_lite_read_arbiter
  import axi_lite_read_arbiter_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi_lite_read_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_M);

  state_t           state_q, state_d;
  logic [NUM_M-1:0] grant_q;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] owner_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0]       arprot_q;

  logic [NUM_M-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             ar_take;
  logic             r_done;

  rr_arbiter #(.NUM_M(NUM_M)) u_rr (
    .req          (bus.m_arvalid),
    .last         (last_q),
    .winner       (win_onehot),
    .winner_idx   (win_idx),
    .winner_valid (win_valid)
  );

  assign bus.s_araddr = araddr_q;
  assign bus.s_arprot = arprot_q;
  assign bus.grant    = grant_q;
  assign bus.m_rdata  = bus.s_rdata;
  assign bus.m_rresp  = bus.s_rresp;

  // Next state and handshake outputs; everything is held quiet during reset.
  always_comb begin
    state_d       = state_q;
    ar_take       = 1'b0;
    r_done        = 1'b0;
    bus.m_arready = '0;
    bus.m_rvalid  = '0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          ar_take       = 1'b1;
          bus.m_arready = win_onehot;
          state_d       = ST_ADDR;
        end
      end
      ST_ADDR: begin
        bus.s_arvalid = 1'b1;
        if (bus.s_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        bus.s_rready = bus.m_rready[owner_q];
        bus.m_rvalid = bus.s_rvalid ? grant_q : '0;
        if (bus.s_rvalid && bus.m_rready[owner_q]) begin
          r_done  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ARESETn) begin
      ar_take       = 1'b0;
      r_done        = 1'b0;
      bus.m_arready = '0;
      bus.m_rvalid  = '0;
      bus.s_arvalid = 1'b0;
      bus.s_rready  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESETn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Latch the winner's request on grant; record the owner as lowest priority on release.
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      grant_q  <= '0;
      last_q   <= IDX_W'(NUM_M - 1);
      owner_q  <= '0;
      araddr_q <= '0;
      arprot_q <= '0;
    end else begin
      if (ar_take) begin
        araddr_q <= bus.m_araddr[int'(win_idx)*ADDR_W +: ADDR_W];
        arprot_q <= bus.m_arprot[int'(win_idx)*3 +: 3];
        grant_q  <= win_onehot;
        owner_q  <= win_idx;
      end
      if (r_done) begin
        last_q  <= owner_q;
        grant_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// tb/tb_axi_lite_read_arbiter.sv - self-checking bench for the AXI4-Lite read arbiter
module tb_axi_lite_read_arbiter;
  import axi_lite_read_arbiter_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   beats = 0;

  axi_lite_read_arbiter_if #(.NUM_M(2), .ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_read_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [2:0]  prot0;
    logic [2:0]  prot1;
    int          ar_delay;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          hold;
    logic [1:0]  exp_grant;
  } vec_t;

  typedef struct {
    logic [1:0]  grant;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mr_e;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: AR handshake compared against the head, R handshake pops it.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      if (bus.s_arvalid && bus.s_arready) begin
        if (exp_q.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          check("s_araddr", bus.s_araddr, exp_q[0].addr);
          check("s_arprot", bus.s_arprot, exp_q[0].prot);
          check("grant_owner", bus.grant, exp_q[0].grant);
        end
      end
      if ((bus.m_rvalid & bus.m_rready) != 2'b00) begin
        if (exp_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          beats++;
          check("m_rvalid_route", bus.m_rvalid, mon_e.grant);
          check("m_rdata", bus.m_rdata, mon_e.data);
          check("m_rresp_beat", bus.m_rresp, mon_e.resp);
        end
      end
    end
  end

  task automatic run_entry(input vec_t v);
    int n;
    exp_t e;
    logic [1:0] own;
    own = v.exp_grant;
    bus.m_arvalid = v.req;
    bus.m_araddr  = {v.addr1, v.addr0};
    bus.m_arprot  = {v.prot1, v.prot0};
    n = 0;
    @(negedge ACLK);
    while (bus.m_arready == 2'b00 && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("ar_latency", n, 0);
    check("m_arready", bus.m_arready, own);
    check("grant_idle", bus.grant, 0);
    e.grant = own;
    e.addr  = own[0] ? v.addr0 : v.addr1;
    e.prot  = own[0] ? v.prot0 : v.prot1;
    e.data  = v.rdata;
    e.resp  = v.rresp;
    exp_q.push_back(e);
    @(posedge ACLK); #1;
    bus.m_arvalid = bus.m_arvalid & ~own;
    repeat (v.ar_delay) begin
      @(negedge ACLK);
      check("s_arvalid_wait", bus.s_arvalid, 1);
      check("s_araddr_hold", bus.s_araddr, e.addr);
      check("m_rvalid_addr", bus.m_rvalid, 0);
      @(posedge ACLK); #1;
    end
    bus.s_arready = 1'b1;
    @(negedge ACLK);
    check("s_arvalid", bus.s_arvalid, 1);
    @(posedge ACLK); #1;
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b1;
    bus.s_rdata   = v.rdata;
    bus.s_rresp   = v.rresp;
    bus.m_rready  = (v.hold > 0) ? ~own : 2'b11;
    repeat (v.hold) begin
      @(negedge ACLK);
      check("s_rready_bp", bus.s_rready, 0);
      check("m_rvalid_bp", bus.m_rvalid, own);
      @(posedge ACLK); #1;
    end
    bus.m_rready = 2'b11;
    @(negedge ACLK);
    check("s_arvalid_data", bus.s_arvalid, 0);
    check("s_rready", bus.s_rready, 1);
    check("m_rresp", bus.m_rresp, v.rresp);
    @(posedge ACLK); #1;
    bus.s_rvalid = 1'b0;
    bus.m_rready = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b01, 32'h0000_1000, 32'h0,          3'd0, 3'd0, 2, 32'hDEAD_BEEF, RESP_OKAY,   0, 2'b01};
    vecs[1] = '{2'b11, 32'h0000_2000, 32'h0000_3000, 3'd1, 3'd2, 0, 32'h1111_1111, RESP_OKAY,   0, 2'b10};
    vecs[2] = '{2'b11, 32'h0000_4000, 32'h0000_5000, 3'd3, 3'd4, 1, 32'h2222_2222, RESP_OKAY,   0, 2'b01};
    vecs[3] = '{2'b11, 32'h0000_6000, 32'h0000_7000, 3'd5, 3'd6, 0, 32'h3333_3333, RESP_EXOKAY, 0, 2'b10};
    vecs[4] = '{2'b11, 32'h0000_8000, 32'h0000_9000, 3'd7, 3'd0, 3, 32'h4444_4444, RESP_OKAY,   0, 2'b01};
    vecs[5] = '{2'b10, 32'h0000_A000, 32'h0000_B000, 3'd2, 3'd5, 0, 32'h5555_5555, RESP_OKAY,   4, 2'b10};
    vecs[6] = '{2'b11, 32'h0000_C000, 32'h0000_D000, 3'd1, 3'd3, 0, 32'h6666_6666, RESP_SLVERR, 0, 2'b01};
    vecs[7] = '{2'b11, 32'h0000_E000, 32'h0000_F000, 3'd4, 3'd6, 1, 32'h7777_7777, RESP_DECERR, 2, 2'b10};
    vecs[8] = '{2'b01, 32'h0001_0000, 32'h0001_1000, 3'd6, 3'd1, 0, 32'h8888_8888, RESP_OKAY,   0, 2'b01};

    bus.m_arvalid = 2'b11;
    bus.m_araddr  = '0;
    bus.m_arprot  = '0;
    bus.m_rready  = 2'b00;
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b0;
    bus.s_rdata   = '0;
    bus.s_rresp   = RESP_OKAY;

    repeat (3) begin
      @(negedge ACLK);
      check("rst_m_arready", bus.m_arready, 0);
      check("rst_m_rvalid", bus.m_rvalid, 0);
      check("rst_s_rready", bus.s_rready, 0);
      check("rst_s_arvalid", bus.s_arvalid, 0);
      check("rst_grant", bus.grant, 0);
      check("rst_s_araddr", bus.s_araddr, 0);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    bus.m_arvalid = 2'b00;

    repeat (2) begin
      @(negedge ACLK);
      check("idle_m_arready", bus.m_arready, 0);
      check("idle_s_arvalid", bus.s_arvalid, 0);
      check("idle_grant", bus.grant, 0);
      @(posedge ACLK); #1;
    end

    for (int i = 0; i < 9; i++) run_entry(vecs[i]);

    bus.m_arvalid = 2'b10;
    bus.m_araddr  = {32'hABCD_0000, 32'h0};
    bus.m_arprot  = {3'd5, 3'd0};
    @(negedge ACLK);
    check("mr_m_arready", bus.m_arready, 2'b10);
    mr_e.grant = 2'b10;
    mr_e.addr  = 32'hABCD_0000;
    mr_e.prot  = 3'd5;
    mr_e.data  = 32'h9999_9999;
    mr_e.resp  = RESP_OKAY;
    exp_q.push_back(mr_e);
    @(posedge ACLK); #1;
    bus.m_arvalid = 2'b00;
    bus.s_arready = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b1;
    bus.s_rdata   = 32'h9999_9999;
    bus.m_rready  = 2'b00;
    @(negedge ACLK);
    check("mr_m_rvalid_data", bus.m_rvalid, 2'b10);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    bus.m_arvalid = 2'b11;
    @(negedge ACLK);
    check("mr_rst_m_rvalid", bus.m_rvalid, 0);
    check("mr_rst_s_rready", bus.s_rready, 0);
    check("mr_rst_m_arready", bus.m_arready, 0);
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    bus.s_rvalid = 1'b0;
    exp_q.delete();
    check("mr_grant_after", bus.grant, 0);
    check("mr_s_arvalid_after", bus.s_arvalid, 0);
    run_entry('{2'b11, 32'h0002_0000, 32'h0002_1000, 3'd3, 3'd7, 0, 32'hCAFE_F00D, RESP_OKAY, 0, 2'b01});

    check("beats_total", beats, 10);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
